// File: rtl/wbs_addr_decoder.sv
// Wishbone address decoder and response router: one master request is routed to the
// lowest-index matching slave, and exactly one registered ack/err pulse is returned.
module wbs_addr_decoder #(
  parameter int                        NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE = '0,
  parameter logic [32*NUM_SLAVES-1:0]  SLAVE_HIGH = '1,
  parameter int                        TIMEOUT    = 1023
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbm_cyc_i,
  input  logic                       wbm_stb_i,
  input  logic                       wbm_we_i,
  input  logic [1:0]                 wbm_sel_i,
  input  logic [31:0]                wbm_adr_i,
  input  logic [15:0]                wbm_dat_i,
  output logic [15:0]                wbm_dat_o,
  output logic                       wbm_ack_o,
  output logic                       wbm_err_o,
  output logic [NUM_SLAVES-1:0]      wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]      wbs_stb_o,
  output logic                       wbs_we_o,
  output logic [1:0]                 wbs_sel_o,
  output logic [31:0]                wbs_adr_o,
  output logic [15:0]                wbs_dat_o,
  input  logic [16*NUM_SLAVES-1:0]   wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]      wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]      wbs_err_i,
  output logic                       timeout_o
);

  localparam int          IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TMO   = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    we_q, we_d;
  logic [1:0]              sel_q, sel_d;
  logic [31:0]             adr_q, adr_d;
  logic [15:0]             wdat_q, wdat_d;
  logic [15:0]             rdat_q, rdat_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    tmo_q, tmo_d;
  logic [NUM_SLAVES-1:0]   cyc_q, cyc_d;

  logic [NUM_SLAVES-1:0]   hit_vec_s;
  logic                    dec_hit_s;
  logic [IDX_W-1:0]        dec_idx_s;
  logic                    sel_ack_s;
  logic                    sel_err_s;
  logic [15:0]             sel_dat_s;

  // Address decode; scanning downward lets the lowest matching index win.
  always_comb begin
    hit_vec_s = '0;
    dec_idx_s = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      hit_vec_s[k] = (wbm_adr_i >= SLAVE_BASE[32*k +: 32]) &&
                     (wbm_adr_i <= SLAVE_HIGH[32*k +: 32]);
      dec_idx_s    = hit_vec_s[k] ? IDX_W'(k) : dec_idx_s;
    end
    dec_hit_s = |hit_vec_s;
  end

  assign sel_ack_s = wbs_ack_i[idx_q];
  assign sel_err_s = wbs_err_i[idx_q];
  assign sel_dat_s = wbs_dat_i[16*idx_q +: 16];

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
    cyc_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          we_d   = wbm_we_i;
          sel_d  = wbm_sel_i;
          adr_d  = wbm_adr_i;
          wdat_d = wbm_dat_i;
          idx_d  = dec_idx_s;
          cnt_d  = 16'd0;
          if (dec_hit_s) begin
            state_d          = ST_ISSUE;
            cyc_d[dec_idx_s] = 1'b1;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        // cnt_q equals the response latency L in both ISSUE and WAIT.
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (sel_err_s) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (sel_ack_s) begin
          ack_d   = 1'b1;
          rdat_d  = we_q ? rdat_q : sel_dat_s;
          state_d = ST_RESP;
        end else if (cnt_q >= TMO) begin
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 2'b00;
      adr_q   <= 32'd0;
      wdat_q  <= 16'd0;
      rdat_q  <= 16'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      cyc_q   <= cyc_d;
    end
  end

  assign wbm_dat_o = rdat_q;
  assign wbm_ack_o = ack_q;
  assign wbm_err_o = err_q;
  assign timeout_o = tmo_q;
  assign wbs_cyc_o = cyc_q;
  assign wbs_stb_o = cyc_q;
  assign wbs_we_o  = we_q;
  assign wbs_sel_o = sel_q;
  assign wbs_adr_o = adr_q;
  assign wbs_dat_o = wdat_q;

endmodule
